// File: rtl/cpu_sequencer.sv
// Microcoded control sequencer: fetch/execute T-state stepping with memory
// stall, conditional jumps and a sticky halt state cleared only by reset.
module cpu_sequencer #(
  parameter int unsigned CW    = 17,
  parameter int unsigned OPW   = 4,
  parameter int unsigned MAX_T = 6,
  localparam int unsigned STW  = $clog2(MAX_T)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] reg_ir,
  input  logic [1:0]     flag_lines,
  input  logic           mem_ready,
  output logic [CW-1:0]  control_lines,
  output logic [STW-1:0] step,
  output logic           instr_done,
  output logic           halted
);

  localparam int unsigned WW = 17;

  localparam int unsigned B_EP  = 0;
  localparam int unsigned B_LM  = 1;
  localparam int unsigned B_C   = 2;
  localparam int unsigned B_LI  = 3;
  localparam int unsigned B_EM  = 4;
  localparam int unsigned B_LA  = 5;
  localparam int unsigned B_EA  = 6;
  localparam int unsigned B_LB  = 7;
  localparam int unsigned B_EB  = 8;
  localparam int unsigned B_LC  = 9;
  localparam int unsigned B_LD  = 10;
  localparam int unsigned B_EI  = 11;
  localparam int unsigned B_LP  = 12;
  localparam int unsigned B_ES  = 13;
  localparam int unsigned B_LO  = 14;
  localparam int unsigned B_SUB = 15;
  localparam int unsigned B_LF  = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_LDB   = 4'h2;
  localparam logic [3:0] OP_MOVAB = 4'h3;
  localparam logic [3:0] OP_MOVBA = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_OUTA  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_LDMA  = 4'hD;
  localparam logic [3:0] OP_MOVAC = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t         state, state_nxt;
  logic [STW-1:0] step_nxt;
  logic [WW-1:0]  word;
  logic           last;
  logic           stall;
  logic [3:0]     op;
  logic [OPW+3:0] ir_ext;
  logic           carry, zero;

  assign carry  = flag_lines[0];
  assign zero   = flag_lines[1];
  assign ir_ext = {4'b0000, reg_ir};
  // Opcodes beyond the 4-bit table execute as NOP
  assign op     = (ir_ext[OPW+3:4] != '0) ? OP_NOP : reg_ir[3:0];
  assign halted = (state == S_HALT);

  // State and step register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Microcode decode, stall handling and step advance
  always_comb begin
    word          = '0;
    last          = 1'b0;
    stall         = 1'b0;
    state_nxt     = state;
    step_nxt      = step;
    control_lines = '0;
    instr_done    = 1'b0;

    if (step == STW'(0)) begin
      word[B_EP] = 1'b1;
      word[B_LM] = 1'b1;
    end else if (step == STW'(1)) begin
      word[B_C]  = 1'b1;
      word[B_LI] = 1'b1;
      word[B_EM] = 1'b1;
    end else if (step == STW'(2)) begin
      last = (op != OP_LDMA);
      case (op)
        OP_LDA:   begin word[B_LA] = 1'b1; word[B_EI] = 1'b1; end
        OP_LDB:   begin word[B_LB] = 1'b1; word[B_EI] = 1'b1; end
        OP_MOVAB: begin word[B_LB] = 1'b1; word[B_EA] = 1'b1; end
        OP_MOVBA: begin word[B_LA] = 1'b1; word[B_EB] = 1'b1; end
        OP_ADD:   begin word[B_LA] = 1'b1; word[B_ES] = 1'b1; word[B_LF] = 1'b1; end
        OP_SUB: begin
          word[B_LA]  = 1'b1;
          word[B_ES]  = 1'b1;
          word[B_SUB] = 1'b1;
          word[B_LF]  = 1'b1;
        end
        OP_OUTA:  begin word[B_EA] = 1'b1; word[B_LO] = 1'b1; end
        OP_JMP:   begin word[B_EI] = 1'b1; word[B_LP] = 1'b1; end
        OP_JC:    begin word[B_EI] = carry;  word[B_LP] = carry;  end
        OP_JNC:   begin word[B_EI] = !carry; word[B_LP] = !carry; end
        OP_JZ:    begin word[B_EI] = zero;   word[B_LP] = zero;   end
        OP_JNZ:   begin word[B_EI] = !zero;  word[B_LP] = !zero;  end
        OP_LDMA:  begin word[B_EI] = 1'b1; word[B_LM] = 1'b1; end
        OP_MOVAC: begin word[B_LC] = 1'b1; word[B_EA] = 1'b1; end
        default:  word = '0;
      endcase
    end else if (step == STW'(3)) begin
      last = 1'b1;
      if (op == OP_LDMA) begin
        word[B_EM] = 1'b1;
        word[B_LA] = 1'b1;
      end
    end else begin
      // Unreachable steps terminate the instruction rather than run away
      last = 1'b1;
    end

    stall = word[B_EM] && !mem_ready;
    if (stall) word[B_C] = 1'b0;

    if (state == S_RUN) begin
      control_lines = CW'(word);
      instr_done    = last && !stall;
      if (!stall) begin
        if (last) begin
          step_nxt = '0;
          if (op == OP_HLT) state_nxt = S_HALT;
        end else begin
          step_nxt = step + STW'(1);
        end
      end
    end

    if (rst) begin
      control_lines = '0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: default build plus a widened build
// (OPW=5, MAX_T=8, CW=20) running alongside on the same clock and reset.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reg_ir;
  logic [1:0]  flag_lines;
  logic        mem_ready;
  logic [16:0] control_lines;
  logic [2:0]  step;
  logic        instr_done;
  logic        halted;

  logic [4:0]  reg_ir2;
  logic [19:0] control_lines2;
  logic [2:0]  step2;
  logic        instr_done2;
  logic        halted2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .reg_ir(reg_ir), .flag_lines(flag_lines),
    .mem_ready(mem_ready), .control_lines(control_lines), .step(step),
    .instr_done(instr_done), .halted(halted)
  );

  cpu_sequencer #(.CW(20), .OPW(5), .MAX_T(8)) dut_wide (
    .clk(clk), .rst(rst), .reg_ir(reg_ir2), .flag_lines(flag_lines),
    .mem_ready(1'b1), .control_lines(control_lines2), .step(step2),
    .instr_done(instr_done2), .halted(halted2)
  );

  // Apply inputs for one cycle just after the falling edge, then let outputs settle
  task automatic drive(input logic r, input logic [3:0] ir, input logic [1:0] f, input logic m);
    @(negedge clk);
    rst        = r;
    reg_ir     = ir;
    flag_lines = f;
    mem_ready  = m;
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] obs, req;
    drive(1'b1, 4'h1, 2'b00, 1'b1);
    drive(1'b1, 4'h1, 2'b00, 1'b1);
    obs = {control_lines, step, instr_done, halted};
    req = {17'h00000, 3'd0, 1'b0, 1'b0};
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL reset_hold got %h expected %h", obs, req);
    end
  endtask

  task automatic test_ld_a();
    logic [16:0] exp_c [4];
    logic [2:0]  exp_s [4];
    logic        exp_d [4];
    exp_c = '{17'h00003, 17'h0001C, 17'h00820, 17'h00003};
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd0};
    exp_d = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 4'h1, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h1, 2'b00, 1'b1);
      n_vec++;
      if ({control_lines, step, instr_done, halted} !== {exp_c[i], exp_s[i], exp_d[i], 1'b0}) begin
        n_bad++;
        $display("FAIL ld_a cycle %0d got ctl=%h step=%0d done=%b halt=%b expected ctl=%h step=%0d done=%b",
                 i, control_lines, step, instr_done, halted, exp_c[i], exp_s[i], exp_d[i]);
      end
    end
  endtask

  // T2 word of every single-step opcode, run back to back without reset.
  // reg_ir and flags are scrambled during fetch to show they are ignored there.
  task automatic test_opcodes();
    logic [3:0]  ops  [14];
    logic [1:0]  fl   [14];
    logic [16:0] t2   [14];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    fl  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    t2  = '{17'h00000, 17'h00820, 17'h00880, 17'h000C0, 17'h00120, 17'h12020, 17'h1A020,
            17'h04040, 17'h01800, 17'h01800, 17'h00000, 17'h01800, 17'h01800, 17'h00240};
    drive(1'b1, 4'h0, 2'b00, 1'b1);
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, ~ops[i], ~fl[i], 1'b1);
      drive(1'b0, 4'hF, ~fl[i], 1'b1);
      n_vec++;
      if ({control_lines, step} !== {17'h0001C, 3'd1}) begin
        n_bad++;
        $display("FAIL op%h_t1 got ctl=%h step=%0d expected ctl=0001c step=1", ops[i], control_lines, step);
      end
      drive(1'b0, ops[i], fl[i], 1'b1);
      n_vec++;
      if ({control_lines, step, instr_done} !== {t2[i], 3'd2, 1'b1}) begin
        n_bad++;
        $display("FAIL op%h_t2 got ctl=%h step=%0d done=%b expected ctl=%h step=2 done=1",
                 ops[i], control_lines, step, instr_done, t2[i]);
      end
    end
  endtask

  task automatic test_jc_timing();
    logic [1:0]  fl [2];
    logic [16:0] t2 [2];
    fl = '{2'b01, 2'b00};
    t2 = '{17'h01800, 17'h00000};
    drive(1'b1, 4'h9, 2'b00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 4'h9, fl[k], 1'b1);
        n_vec++;
        if ({step, instr_done} !== {3'(i), (i == 2)}) begin
          n_bad++;
          $display("FAIL jc%0d_cycle%0d got step=%0d done=%b expected step=%0d", k, i, step, instr_done, i);
        end
        if (i == 2) begin
          n_vec++;
          if (control_lines !== t2[k]) begin
            n_bad++;
            $display("FAIL jc%0d_t2 got %h expected %h", k, control_lines, t2[k]);
          end
        end
      end
    end
  endtask

  task automatic test_ldm_stall();
    logic [16:0] exp_c [7];
    logic [2:0]  exp_s [7];
    logic        exp_d [7];
    logic        mr    [7];
    exp_c = '{17'h00003, 17'h0001C, 17'h00802, 17'h00030, 17'h00030, 17'h00030, 17'h00003};
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 4'hD, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'hD, 2'b00, mr[i]);
      n_vec++;
      if ({control_lines, step, instr_done} !== {exp_c[i], exp_s[i], exp_d[i]}) begin
        n_bad++;
        $display("FAIL ldm cycle %0d got ctl=%h step=%0d done=%b expected ctl=%h step=%0d done=%b",
                 i, control_lines, step, instr_done, exp_c[i], exp_s[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_fetch_stall();
    drive(1'b1, 4'h1, 2'b00, 1'b1);
    drive(1'b0, 4'h1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h1, 2'b00, 1'b0);
      n_vec++;
      if ({control_lines, step, instr_done} !== {17'h00018, 3'd1, 1'b0}) begin
        n_bad++;
        $display("FAIL fetch_stall %0d got ctl=%h step=%0d done=%b expected ctl=00018 step=1 done=0",
                 i, control_lines, step, instr_done);
      end
    end
    drive(1'b0, 4'h1, 2'b00, 1'b1);
    n_vec++;
    if ({control_lines, step} !== {17'h0001C, 3'd1}) begin
      n_bad++;
      $display("FAIL fetch_release got ctl=%h step=%0d expected ctl=0001c step=1", control_lines, step);
    end
    drive(1'b0, 4'h1, 2'b00, 1'b1);
    n_vec++;
    if ({control_lines, step, instr_done} !== {17'h00820, 3'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL fetch_then_t2 got ctl=%h step=%0d done=%b expected ctl=00820 step=2 done=1",
               control_lines, step, instr_done);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 4'hF, 2'b00, 1'b1);
    drive(1'b0, 4'hF, 2'b00, 1'b1);
    drive(1'b0, 4'hF, 2'b00, 1'b1);
    drive(1'b0, 4'hF, 2'b00, 1'b1);
    n_vec++;
    if ({control_lines, step, instr_done, halted} !== {17'h00000, 3'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL hlt_t2 got ctl=%h step=%0d done=%b halt=%b expected ctl=0 step=2 done=1 halt=0",
               control_lines, step, instr_done, halted);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'(i), 2'(i), 1'(i));
      n_vec++;
      if ({control_lines, step, instr_done, halted} !== {17'h00000, 3'd0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL halted %0d got ctl=%h step=%0d done=%b halt=%b expected ctl=0 step=0 done=0 halt=1",
                 i, control_lines, step, instr_done, halted);
      end
    end
    drive(1'b1, 4'h1, 2'b00, 1'b1);
    drive(1'b0, 4'h1, 2'b00, 1'b1);
    n_vec++;
    if ({control_lines, step, halted} !== {17'h00003, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL halt_exit got ctl=%h step=%0d halt=%b expected ctl=00003 step=0 halt=0",
               control_lines, step, halted);
    end
  endtask

  // Reset asserted during a stalled memory step abandons the instruction
  task automatic test_reset_mid();
    drive(1'b1, 4'hD, 2'b00, 1'b1);
    drive(1'b0, 4'hD, 2'b00, 1'b1);
    drive(1'b0, 4'hD, 2'b00, 1'b1);
    drive(1'b0, 4'hD, 2'b00, 1'b1);
    drive(1'b0, 4'hD, 2'b00, 1'b0);
    drive(1'b1, 4'hD, 2'b00, 1'b0);
    n_vec++;
    if ({control_lines, instr_done} !== {17'h00000, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_during_stall got ctl=%h done=%b expected ctl=0 done=0", control_lines, instr_done);
    end
    drive(1'b0, 4'hD, 2'b00, 1'b0);
    n_vec++;
    if ({control_lines, step} !== {17'h00003, 3'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_resume got ctl=%h step=%0d expected ctl=00003 step=0", control_lines, step);
    end
  endtask

  task automatic test_wide();
    logic [19:0] exp_c [4];
    logic [2:0]  exp_s [4];
    logic        exp_d [4];
    exp_c = '{20'h00003, 20'h0001C, 20'h00000, 20'h00003};
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd0};
    exp_d = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 4'h0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 2'b11, 1'b1);
      n_vec++;
      if ({control_lines2, step2, instr_done2, halted2} !== {exp_c[i], exp_s[i], exp_d[i], 1'b0}) begin
        n_bad++;
        $display("FAIL wide cycle %0d got ctl=%h step=%0d done=%b halt=%b expected ctl=%h step=%0d done=%b",
                 i, control_lines2, step2, instr_done2, halted2, exp_c[i], exp_s[i], exp_d[i]);
      end
      n_vec++;
      if (control_lines2[19:17] !== 3'b000) begin
        n_bad++;
        $display("FAIL wide_upper %0d got %b expected 000", i, control_lines2[19:17]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    reg_ir     = '0;
    reg_ir2    = 5'h13;
    flag_lines = '0;
    mem_ready  = 1'b1;
    test_reset();
    test_ld_a();
    test_opcodes();
    test_jc_timing();
    test_ldm_stall();
    test_fetch_stall();
    test_halt();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
